// File: rtl/demux_3_stream.sv
// Steers one valid/ready stream to one of three registered output channels; select code 3 is sunk and counted.
// Latency: 1 cycle from input accept to output valid/data; drop_o/drop_cnt_o also 1 cycle after the invalid accept.
// Backpressure: input stalls only while the selected channel is full and not draining; invalid selects never stall.
module demux_3_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [1:0]            select_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [2:0]            m_valid_o,
   input  logic [2:0]            m_ready_i,
   output logic [DATA_WIDTH-1:0] data_0_o,
   output logic [DATA_WIDTH-1:0] data_1_o,
   output logic [DATA_WIDTH-1:0] data_2_o,
   output logic                  drop_o,
   output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

   logic [2:0]            valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q [3];
   logic [DATA_WIDTH-1:0] data_d [3];
   logic                  drop_q, drop_d;
   logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
   logic                  accept;

   // Ready when the selected slot is empty or draining this cycle; code 3 is always sunk.
   always_comb begin
      s_ready_o = 1'b1;
      case (select_i)
         2'd0:    s_ready_o = !valid_q[0] || m_ready_i[0];
         2'd1:    s_ready_o = !valid_q[1] || m_ready_i[1];
         2'd2:    s_ready_o = !valid_q[2] || m_ready_i[2];
         default: s_ready_o = 1'b1;
      endcase
   end

   assign accept = s_valid_i && s_ready_o;

   // Slot updates: drain frees a slot, a load on the same edge keeps it full with the new beat.
   always_comb begin
      valid_d    = valid_q;
      data_d     = data_q;
      drop_d     = accept && (select_i == 2'd3);
      drop_cnt_d = drop_cnt_q;
      for (int n = 0; n < 3; n++) begin
         if (valid_q[n] && m_ready_i[n]) begin
            valid_d[n] = 1'b0;
         end
         if (accept && (select_i == 2'(n))) begin
            valid_d[n] = 1'b1;
            data_d[n]  = data_i;
         end
      end
      if (drop_d && (drop_cnt_q != {CNT_WIDTH{1'b1}})) begin
         drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
      end
   end

   // State registers with synchronous reset; reset discards any held beats.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q    <= 3'b000;
         data_q     <= '{default: '0};
         drop_q     <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         valid_q    <= valid_d;
         data_q     <= data_d;
         drop_q     <= drop_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign m_valid_o  = valid_q;
   assign data_0_o   = data_q[0];
   assign data_1_o   = data_q[1];
   assign data_2_o   = data_q[2];
   assign drop_o     = drop_q;
   assign drop_cnt_o = drop_cnt_q;

endmodule
